// File: rtl/spart_brg_param.sv
// spart_brg_param: parametrised baud rate generator for the SPART family.
// Produces an oversample tick (os_tick_o) and a full-bit tick (bit_tick_o)
// from a bus-programmable integer divisor. Divisor updates are staged and
// committed only at a counter rollover or at an RX phase resync.
//
// Optional feature macro: SPART_BRG_FRAC_EN
//   defined   - fractional divisor register (addr 2) and accumulator; a carry
//               out of the accumulator stretches the next period by one cycle.
//   undefined - no fractional logic, addr 2 writes are ignored, period is
//               always div_active + 1.
//
// Register map (wr_addr_i):
//   0 : staging divisor [7:0]
//   1 : staging divisor [DIV_W-1:8], arms the commit at the next rollover
//   2 : fractional divisor (FRAC_W LSBs of wr_data_i)
//   3 : reserved, writes ignored

module spart_brg_param #(
    parameter int DIV_W   = 16,
    parameter int OVS     = 16,
    parameter int RST_DIV = 650,
    parameter int FRAC_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_addr_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rx_resync_i,
    output logic             os_tick_o,
    output logic             bit_tick_o,
    output logic [DIV_W-1:0] div_active_o
);

    // The period counter needs one extra bit: a carry can load div + 1.
    localparam int CNT_W = DIV_W + 1;
    localparam int HI_W  = DIV_W - 8;
    localparam int OS_W  = (OVS > 1) ? $clog2(OVS) : 1;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(RST_DIV);
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RST_DIV);
    localparam logic [OS_W-1:0]  OS_TOP  = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVS / 2 - 1);

    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [DIV_W-1:0] staging_q, staging_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;

    logic [DIV_W-1:0] div_eff;
    logic             cnt_zero;
    logic             carry;
    logic             wr_lo, wr_hi, wr_frac;
    logic             unused_wr_bits;

    assign wr_lo   = wr_en_i && (wr_addr_i == 2'd0);
    assign wr_hi   = wr_en_i && (wr_addr_i == 2'd1);
    assign wr_frac = wr_en_i && (wr_addr_i == 2'd2);

    // Not every data bit lands in a register for every parameter choice.
    assign unused_wr_bits = ^{wr_data_i, wr_frac};

    // A pending commit is applied before the value is used for reload.
    assign div_eff  = pending_q ? staging_q : div_active_q;
    assign cnt_zero = (cnt_q == '0);

`ifdef SPART_BRG_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic [FRAC_W:0]   frac_sum;

    assign frac_sum = {1'b0, frac_acc_q} + {1'b0, frac_q};
    assign carry    = frac_sum[FRAC_W];

    // Fractional register and accumulator next-state.
    always_comb begin
        frac_d     = frac_q;
        frac_acc_d = frac_acc_q;
        if (wr_frac) begin
            frac_d = wr_data_i[FRAC_W-1:0];
        end
        if (en_i) begin
            if (rx_resync_i) begin
                frac_acc_d = '0;
            end else if (cnt_zero) begin
                frac_acc_d = frac_sum[FRAC_W-1:0];
            end
        end
    end

    // Fractional state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frac_q     <= '0;
            frac_acc_q <= '0;
        end else begin
            frac_q     <= frac_d;
            frac_acc_q <= frac_acc_d;
        end
    end
`else
    assign carry = 1'b0;
`endif

    // Staging register, commit flag, period and oversample counters.
    always_comb begin
        staging_d    = staging_q;
        div_active_d = div_active_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        os_cnt_d     = os_cnt_q;

        if (wr_lo) begin
            staging_d[7:0] = wr_data_i;
        end
        if (wr_hi) begin
            staging_d[DIV_W-1:8] = wr_data_i[HI_W-1:0];
        end

        if (en_i) begin
            if (rx_resync_i) begin
                div_active_d = div_eff;
                pending_d    = 1'b0;
                cnt_d        = {1'b0, div_eff};
                os_cnt_d     = OS_MID;
            end else if (cnt_zero) begin
                div_active_d = div_eff;
                pending_d    = 1'b0;
                cnt_d        = {1'b0, div_eff} + CNT_W'(carry);
                os_cnt_d     = (os_cnt_q == '0) ? OS_TOP : os_cnt_q - OS_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // A high-byte write landing on a rollover arms the next rollover,
        // so it overrides the clear above.
        if (wr_hi) begin
            pending_d = 1'b1;
        end
    end

    // Main state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_active_q <= DIV_RST;
            staging_q    <= DIV_RST;
            pending_q    <= 1'b0;
            cnt_q        <= CNT_RST;
            os_cnt_q     <= OS_TOP;
        end else begin
            div_active_q <= div_active_d;
            staging_q    <= staging_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            os_cnt_q     <= os_cnt_d;
        end
    end

    assign os_tick_o    = en_i && !rx_resync_i && cnt_zero;
    assign bit_tick_o   = os_tick_o && (os_cnt_q == '0);
    assign div_active_o = div_active_q;

endmodule

// File: tb/tb_spart_brg_param.sv
// Self-checking bench for spart_brg_param (default parameters).
// Expected tick intervals are queued when stimulus is applied and popped as
// the DUT produces os_tick pulses.

module tb_spart_brg_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [1:0]  wr_addr_i = 2'd0;
    logic [7:0]  wr_data_i = 8'd0;
    logic        rx_resync_i = 1'b0;
    logic        os_tick_o;
    logic        bit_tick_o;
    logic [15:0] div_active_o;

    spart_brg_param dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .rx_resync_i  (rx_resync_i),
        .os_tick_o    (os_tick_o),
        .bit_tick_o   (bit_tick_o),
        .div_active_o (div_active_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   gap;
        logic bt;
    } exp_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] fr;
        int         div;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_tick = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        step();
        wr_en_i   = 1'b0;
    endtask

    task automatic push(input int gap, input logic bt, input int n);
        exp_t e;
        e.gap = gap;
        e.bt  = bt;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        int   n;
        e = exp_q.pop_front();
        n = 0;
        do begin
            step();
            n++;
        end while (!os_tick_o && n < e.gap + 20);
        if (!os_tick_o) begin
            check({name, " timeout"}, 0, 1);
        end else begin
            check({name, " gap"}, cyc - last_tick, e.gap);
            check({name, " bit_tick"}, bit_tick_o, e.bt);
        end
        last_tick = cyc;
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) pop_check(name);
    endtask

    // Pulse rx_resync for the current cycle; that cycle must not tick.
    task automatic resync_now();
        rx_resync_i = 1'b1;
        #1;
        check("resync os_tick", os_tick_o, 0);
        check("resync bit_tick", bit_tick_o, 0);
        @(posedge clk);
        #1;
        rx_resync_i = 1'b0;
        last_tick = cyc;
    endtask

    initial begin
        logic any_tick;
        int   acc, sum, fr_eff;

        vecs[0] = '{lo: 8'h03, hi: 8'h00, fr: 8'h00, div: 3};
        vecs[1] = '{lo: 8'h03, hi: 8'h00, fr: 8'h08, div: 3};
        vecs[2] = '{lo: 8'h00, hi: 8'h00, fr: 8'h00, div: 0};
        vecs[3] = '{lo: 8'h0A, hi: 8'h00, fr: 8'h04, div: 10};
        vecs[4] = '{lo: 8'h05, hi: 8'h01, fr: 8'h00, div: 261};
        vecs[5] = '{lo: 8'h07, hi: 8'h00, fr: 8'h0C, div: 7};

        // Reset and default divisor.
        en_i = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("reset div_active", div_active_o, 650);
        check("reset os_tick", os_tick_o, 0);
        check("reset bit_tick", bit_tick_o, 0);
        last_tick = cyc;
        push(650, 1'b0, 1);
        push(651, 1'b0, 14);
        push(651, 1'b1, 1);
        drain("default");

        // Mid-count divisor change commits only at the rollover.
        repeat (100) step();
        wr(2'd0, 8'h03);
        wr(2'd1, 8'h00);
        check("pending div_active", div_active_o, 650);
        push(651, 1'b0, 1);
        push(4, 1'b0, 14);
        push(4, 1'b1, 1);
        push(4, 1'b0, 15);
        push(4, 1'b1, 1);
        drain("div3");
        check("div3 div_active", div_active_o, 3);

        // Low byte alone, or strobe-less addr 1 traffic, never commits.
        wr(2'd0, 8'h10);
        for (int i = 0; i < 4; i++) begin
            wr_addr_i = 2'd1;
            wr_data_i = 8'($urandom);
            push(4, 1'b0, 1);
            pop_check("no_commit");
        end
        wr_addr_i = 2'd0;
        check("no_commit div_active", div_active_o, 3);

        // Resync at cnt==1, then resync on a rollover cycle.
        repeat (3) step();
        resync_now();
        push(4, 1'b0, 7);
        push(4, 1'b1, 1);
        drain("resync_cnt1");
        push(4, 1'b0, 1);
        pop_check("pre_resync");
        resync_now();
        push(4, 1'b0, 7);
        push(4, 1'b1, 1);
        drain("resync_zero");

        // en=0 freeze with writes and an ignored resync.
        repeat (2) step();
        en_i = 1'b0;
        any_tick = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 10) wr(2'd0, 8'h05);
            else if (k == 11) wr(2'd1, 8'h00);
            else if (k == 50) begin
                rx_resync_i = 1'b1;
                step();
                any_tick = any_tick | os_tick_o | bit_tick_o;
                rx_resync_i = 1'b0;
            end else begin
                step();
                any_tick = any_tick | os_tick_o | bit_tick_o;
            end
        end
        check("en0 no ticks", any_tick, 0);
        check("en0 div_active", div_active_o, 3);
        en_i = 1'b1;
        push(104, 1'b0, 1);
        push(6, 1'b0, 2);
        drain("en_resume");
        check("en_resume div_active", div_active_o, 5);

        // Table of divisor/fraction settings, aligned by a resync.
        foreach (vecs[v]) begin
            wr(2'd0, vecs[v].lo);
            wr(2'd1, vecs[v].hi);
            wr(2'd2, vecs[v].fr);
            resync_now();
`ifdef SPART_BRG_FRAC_EN
            fr_eff = int'(vecs[v].fr[3:0]);
`else
            fr_eff = 0;
`endif
            acc = 0;
            push(vecs[v].div + 1, 1'b0, 1);
            for (int i = 1; i < 8; i++) begin
                sum = acc + fr_eff;
                acc = sum % 16;
                push(vecs[v].div + 1 + ((sum >= 16) ? 1 : 0), (i == 7), 1);
            end
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d div_active", v), div_active_o, vecs[v].div);
        end

        // Reset mid-count restores defaults, including the fraction.
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2 div_active", div_active_o, 650);
        check("rst2 os_tick", os_tick_o, 0);
        check("rst2 bit_tick", bit_tick_o, 0);
        last_tick = cyc;
        push(650, 1'b0, 1);
        push(651, 1'b0, 2);
        drain("rst2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
